// File: rtl/disaggregator.sv
// disaggregator: pops one FETCH_WIDTH-lane bundle from an FWFT FIFO and
// replays its lanes, lane 0 first, one word per cycle into a narrow FIFO.
module disaggregator #(
  parameter int DATA_WIDTH  = 11,
  parameter int FETCH_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              receiver_last
);
  localparam int IW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
  typedef enum logic {EMPTY, DRAIN} state_t;
  state_t                            valid_q, valid_d;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic                              last_lane;
  always_comb begin
    last_lane     = idx_q == IW'(FETCH_WIDTH - 1);
    receiver_data = buf_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    receiver_enq  = valid_q == DRAIN && receiver_full_n;
    receiver_last = receiver_enq && last_lane;
    // refill is allowed only once the last lane actually leaves, so a stall blocks it
    sender_deq    = rst_n && sender_empty_n && (valid_q == EMPTY || receiver_last);
    buf_d         = sender_deq ? sender_data : buf_q;
    idx_d         = (sender_deq || receiver_last) ? '0 : receiver_enq ? idx_q + 1'b1 : idx_q;
    valid_d       = sender_deq ? DRAIN : receiver_last ? EMPTY : valid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      idx_q   <= '0;
      valid_q <= EMPTY;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_disaggregator.sv
// tb_disaggregator: random FIFO-backed traffic checked against a word-queue model
// of the bundles popped but not yet emitted.
module tb_disaggregator;
  localparam int DW = 11;
  localparam int FW = 4;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [FW*DW-1:0]  sender_data;
  logic              sender_empty_n;
  logic              sender_deq;
  logic [DW-1:0]     receiver_data;
  logic              receiver_full_n;
  logic              receiver_enq;
  logic              receiver_last;
  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n), .sender_data(sender_data), .sender_empty_n(sender_empty_n),
    .sender_deq(sender_deq), .receiver_data(receiver_data), .receiver_full_n(receiver_full_n),
    .receiver_enq(receiver_enq), .receiver_last(receiver_last)
  );
  always #5 clk = ~clk;
  logic [FW*DW-1:0] sq[$];
  logic [DW-1:0]    exp_q[$];
  int               nvec = 0, nerr = 0;
  int               full_pct = 100, empty_pct = 100;
  int               wc = 0, enq_cnt = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    nvec++;
    if (obs !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, req, $time);
    end
  endtask
  task automatic push_bundle();
    logic [FW*DW-1:0] b;
    for (int i = 0; i < FW; i++) b[i*DW +: DW] = DW'(wc + i);
    wc += FW;
    sq.push_back(b);
  endtask
  // one cycle: drive inputs after negedge, predict and check outputs, advance model
  task automatic step(input bit rst);
    logic e_enq, e_deq;
    logic [FW*DW-1:0] b;
    @(negedge clk);
    rst_n = !rst;
    if (rst) exp_q.delete();
    receiver_full_n = $urandom_range(99) < full_pct;
    sender_empty_n  = sq.size() > 0 && $urandom_range(99) < empty_pct;
    sender_data     = sender_empty_n ? sq[0] : {$urandom, $urandom};
    #1;
    e_enq = !rst && receiver_full_n && exp_q.size() > 0;
    e_deq = !rst && sender_empty_n && (exp_q.size() == 0 || (exp_q.size() == 1 && receiver_full_n));
    check("enq", 32'(receiver_enq), 32'(e_enq));
    check("deq", 32'(sender_deq), 32'(e_deq));
    check("last", 32'(receiver_last), 32'(e_enq && exp_q.size() == 1));
    if (exp_q.size() > 0) check("data", 32'(receiver_data), 32'(exp_q[0]));
    else if (rst) check("rst_data", 32'(receiver_data), 32'd0);
    if (e_enq) begin
      void'(exp_q.pop_front());
      enq_cnt++;
    end
    if (e_deq) begin
      b = sq.pop_front();
      for (int i = 0; i < FW; i++) exp_q.push_back(b[i*DW +: DW]);
    end
  endtask
  task automatic run_until(input int remaining);
    int n = 0;
    while (exp_q.size() != remaining && n < 40) begin
      step(1'b0);
      n++;
    end
    check("reach", 32'(exp_q.size()), 32'(remaining));
  endtask
  initial begin
    rst_n = 1'b0;
    sender_empty_n = 1'b0;
    receiver_full_n = 1'b0;
    sender_data = '0;
    push_bundle();
    repeat (3) step(1'b1);
    repeat (6) step(1'b0);
    repeat (4) push_bundle();
    step(1'b0);
    enq_cnt = 0;
    repeat (16) step(1'b0);
    check("stream", 32'(enq_cnt), 32'd16);
    repeat (6) step(1'b0);
    repeat (2) push_bundle();
    run_until(1);
    full_pct = 0;
    repeat (3) step(1'b0);
    full_pct = 100;
    step(1'b0);
    run_until(0);
    repeat (2) push_bundle();
    run_until(FW - 2);
    step(1'b1);
    repeat (10) step(1'b0);
    full_pct = 60;
    empty_pct = 60;
    for (int c = 0; c < 2000; c++) begin
      if (sq.size() < 3 && $urandom_range(3) != 0) push_bundle();
      step(1'b0);
    end
    full_pct = 100;
    empty_pct = 100;
    repeat (40) step(1'b0);
    check("drained", 32'(exp_q.size() + sq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
